ls_preload_ctrl: RTL and testbench

Streams a program or data image from a 32-bit host word stream into the SPU Local Store through its preload port. It assembles four big-endian words into one 128-bit quadword and issues one single-cycle `preload_LS_en` write per quadword at consecutive quadword addresses. It sits between the testbench or host loader and the odd pipe's Local Store preload inputs, and is the driving end of the `preload_LS_en` / `preload_LS_addr` / `preload_LS_data` interface. `busy` is high for the whole transfer, so the core can be held off while the load runs.

---
 rtl/ls_preload_ctrl_pkg.sv | 19 +
 rtl/ls_preload_ctrl_if.sv | 38 +++
 rtl/ls_preload_ctrl_qw_assembler.sv | 50 +++++
 rtl/ls_preload_ctrl.sv | 126 ++++++++++++
 tb/tb_ls_preload_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_preload_ctrl_pkg.sv
// Shared constants and state encoding for the Local Store preload controller.
package ls_preload_ctrl_pkg;

  localparam int unsigned LS_ADDR_W    = 15;
  localparam int unsigned QW_BYTES     = 16;
  localparam int unsigned WORDS_PER_QW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [0:LS_ADDR_W-1] qw_align(input logic [0:LS_ADDR_W-1] a);
    return {a[0:LS_ADDR_W-5], 4'b0000};
  endfunction

endpackage

// File: rtl/ls_preload_ctrl_if.sv
// Host stream / Local Store preload bundle; checksum exists only with LS_PRELOAD_CHECKSUM_EN.
interface ls_preload_ctrl_if #(parameter int unsigned CNT_W = 12);
  import ls_preload_ctrl_pkg::*;

  logic                   start;
  logic [0:LS_ADDR_W-1]   start_addr;
  logic [CNT_W-1:0]       start_count;
  logic                   in_valid;
  logic [0:31]            in_data;
  logic                   in_ready;
  logic                   preload_LS_en;
  logic [0:LS_ADDR_W-1]   preload_LS_addr;
  logic [0:127]           preload_LS_data;
  logic                   busy;
  logic                   done;
`ifdef LS_PRELOAD_CHECKSUM_EN
  logic [0:31]            checksum;

  modport master (
    output start, start_addr, start_count, in_valid, in_data,
    input  in_ready, preload_LS_en, preload_LS_addr, preload_LS_data, busy, done, checksum
  );
  modport slave (
    input  start, start_addr, start_count, in_valid, in_data,
    output in_ready, preload_LS_en, preload_LS_addr, preload_LS_data, busy, done, checksum
  );
`else
  modport master (
    output start, start_addr, start_count, in_valid, in_data,
    input  in_ready, preload_LS_en, preload_LS_addr, preload_LS_data, busy, done
  );
  modport slave (
    input  start, start_addr, start_count, in_valid, in_data,
    output in_ready, preload_LS_en, preload_LS_addr, preload_LS_data, busy, done
  );
`endif

endinterface

// File: rtl/ls_preload_ctrl_qw_assembler.sv
// Packs four big-endian 32-bit words into one quadword; word k lands in bits [32k:32k+31].
module preload_qw_assembler
  import ls_preload_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [0:31]  word_in,
  output logic         full,
  output logic [0:127] qw_out
);

  logic [1:0]  idx_q, idx_d;
  logic [0:31] slot_q [WORDS_PER_QW];
  logic [0:31] slot_d [WORDS_PER_QW];

  always_comb begin
    idx_d  = idx_q;
    slot_d = slot_q;
    if (clear) begin
      idx_d = '0;
    end else if (push) begin
      slot_d[idx_q] = word_in;
      idx_d         = idx_q + 2'd1;
    end
  end

  // full and qw_out look through the current push so the owner can capture the
  // completed quadword on the same edge that accepts the last word.
  assign full = push && !clear && (idx_q == 2'd3);

  always_comb begin
    qw_out = '0;
    for (int unsigned i = 0; i < WORDS_PER_QW; i++) begin
      qw_out[32*i +: 32] = slot_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int unsigned i = 0; i < WORDS_PER_QW; i++) slot_q[i] <= '0;
    end else begin
      idx_q  <= idx_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/ls_preload_ctrl.sv
// Streams host words into the Local Store preload port one quadword at a time.
// Optional checksum register/port: define LS_PRELOAD_CHECKSUM_EN.
module ls_preload_ctrl
  import ls_preload_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input logic              clk,
  input logic              rst_n,
  ls_preload_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [0:LS_ADDR_W-1] addr_q, addr_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 en_q, en_d;
  logic [0:LS_ADDR_W-1] pl_addr_q, pl_addr_d;
  logic [0:127]         pl_data_q, pl_data_d;
`ifdef LS_PRELOAD_CHECKSUM_EN
  logic [0:31]          csum_q, csum_d;
`endif

  logic         asm_clear;
  logic         asm_push;
  logic         asm_full;
  logic [0:127] asm_qw;

  assign asm_clear = (state_q == ST_IDLE) && bus.start;
  assign asm_push  = (state_q == ST_FILL) && bus.in_valid && in_ready_q;

  preload_qw_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (asm_clear),
    .push    (asm_push),
    .word_in (bus.in_data),
    .full    (asm_full),
    .qw_out  (asm_qw)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    pl_addr_d = pl_addr_q;
    pl_data_d = pl_data_q;
    en_d      = 1'b0;
`ifdef LS_PRELOAD_CHECKSUM_EN
    csum_d    = csum_q;
    if (asm_clear) csum_d = '0;
    if (asm_push)  csum_d = csum_q ^ bus.in_data;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = qw_align(bus.start_addr);
          rem_d   = bus.start_count;
          state_d = (bus.start_count != '0) ? ST_FILL : ST_DONE;
        end
      end
      ST_FILL: begin
        if (asm_full) begin
          state_d   = ST_WRITE;
          en_d      = 1'b1;
          pl_addr_d = addr_q;
          pl_data_d = asm_qw;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + LS_ADDR_W'(QW_BYTES);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_FILL;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the state being entered.
    in_ready_d = (state_d == ST_FILL);
    busy_d     = (state_d == ST_FILL) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      pl_addr_q  <= '0;
      pl_data_q  <= '0;
`ifdef LS_PRELOAD_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
      pl_addr_q  <= pl_addr_d;
      pl_data_q  <= pl_data_d;
`ifdef LS_PRELOAD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.preload_LS_en   = en_q;
  assign bus.preload_LS_addr = pl_addr_q;
  assign bus.preload_LS_data = pl_data_q;
`ifdef LS_PRELOAD_CHECKSUM_EN
  assign bus.checksum        = csum_q;
`endif

endmodule

// File: tb/tb_ls_preload_ctrl.sv
// Self-checking bench for ls_preload_ctrl; checksum scenario runs when LS_PRELOAD_CHECKSUM_EN is defined.
module tb_ls_preload_ctrl;

  localparam int unsigned CNT_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ls_preload_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ls_preload_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [14:0]  addr;
    logic [127:0] data;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;

  // Observation state, recorded at negedge, away from the active edge.
  wr_t act_q[$];
  int  en_cyc_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  en_long = 0;
  int  ir_bad = 0;
  int  busy_cycles = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.preload_LS_en) begin
      act_q.push_back('{addr: bus.preload_LS_addr, data: bus.preload_LS_data});
      en_cyc_q.push_back(cyc);
      if (en_prev) en_long++;
    end
    en_prev = bus.preload_LS_en;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy) busy_cycles++;
    if (bus.in_ready && (!bus.busy || bus.preload_LS_en)) ir_bad++;
  end

  // Transfer driver state
  logic [31:0] words[$];
  bit          tmo;
  bit          first_busy;
  int          start_cyc;

  // mode 0: full rate, 1: valid every other cycle, 2: random gaps
  task automatic xfer(input logic [14:0] a, input int unsigned cnt, input int unsigned mode,
                      input bit wait_done);
    int unsigned k = 0;
    int budget = 0;
    int d0;
    bit acc;
    tmo = 1'b0;
    d0  = done_cnt;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.start_addr  = a;
    bus.start_count = CNT_W'(cnt);
    bus.in_valid    = (words.size() > 0);
    bus.in_data     = (words.size() > 0) ? words[0] : 32'h0;
    start_cyc       = cyc;
    @(negedge clk);
    bus.start  = 1'b0;
    first_busy = bus.busy && bus.in_ready;
    while (k < words.size()) begin
      bus.in_data  = words[k];
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (budget % 2 == 0);
        default: bus.in_valid = ($urandom_range(99) >= 35);
      endcase
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) k++;
      budget++;
      if (budget > 1000) begin
        tmo = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (wait_done && !tmo) begin
      budget = 0;
      while (done_cnt == d0 && budget < 60) begin
        @(negedge clk);
        budget++;
      end
      if (done_cnt == d0) tmo = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  function automatic logic [14:0] exp_addr(input logic [14:0] a, input int unsigned i);
    int unsigned base = int'(a) - (int'(a) % 16);
    return 15'((base + 16 * i) % 32768);
  endfunction

  function automatic logic [127:0] exp_data(input int unsigned i);
    return {words[4*i], words[4*i+1], words[4*i+2], words[4*i+3]};
  endfunction

  task automatic clear_obs();
    act_q.delete();
    en_cyc_q.delete();
    en_long     = 0;
    ir_bad      = 0;
    busy_cycles = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.start_addr = '0; bus.start_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    rst_n = 1'b0;
    #23;
    vectors++;
    if ({bus.in_ready, bus.preload_LS_en, bus.busy, bus.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.in_ready, bus.preload_LS_en, bus.busy, bus.done});
    end
    vectors++;
    if (bus.preload_LS_addr !== 15'h0 || bus.preload_LS_data !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr %h data %h want 0", bus.preload_LS_addr, bus.preload_LS_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_qw();
    clear_obs();
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    xfer(15'h0100, 1, 0, 1);
    vectors++;
    if (tmo || act_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_count: writes %0d tmo %0d want 1 write", act_q.size(), tmo);
    end else begin
      vectors++;
      if (act_q[0].addr !== 15'h0100 ||
          act_q[0].data !== 128'h11111111_22222222_33333333_44444444) begin
        miscompares++;
        $display("FAIL single_write: addr %h data %h want 0100 / 11111111_..._44444444",
                 act_q[0].addr, act_q[0].data);
      end
      vectors++;
      if (done_cyc != en_cyc_q[0] + 1 || en_long != 0) begin
        miscompares++;
        $display("FAIL single_done_timing: done@%0d en@%0d en_long %0d want done=en+1, 1-cycle en",
                 done_cyc, en_cyc_q[0], en_long);
      end
      // Full-rate input: first word accepted one edge after start, so en arrives 5 cycles in.
      vectors++;
      if (en_cyc_q[0] != start_cyc + 5) begin
        miscompares++;
        $display("FAIL single_latency: en@%0d want %0d", en_cyc_q[0], start_cyc + 5);
      end
    end
    vectors++;
    if (first_busy !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy: busy/in_ready after start %0d, busy at end %0d want 1/0",
               first_busy, bus.busy);
    end
  endtask

  task automatic test_unaligned_gapped();
    clear_obs();
    words.delete();
    for (int unsigned i = 0; i < 12; i++) words.push_back($urandom);
    xfer(15'h0107, 3, 1, 1);
    vectors++;
    if (tmo || act_q.size() != 3) begin
      miscompares++;
      $display("FAIL gapped_count: writes %0d tmo %0d want 3", act_q.size(), tmo);
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        vectors++;
        if (act_q[i].addr !== exp_addr(15'h0107, i) || act_q[i].data !== exp_data(i)) begin
          miscompares++;
          $display("FAIL gapped_write%0d: addr %h data %h want %h / %h", i,
                   act_q[i].addr, act_q[i].data, exp_addr(15'h0107, i), exp_data(i));
        end
      end
    end
    vectors++;
    if (ir_bad != 0) begin
      miscompares++;
      $display("FAIL gapped_in_ready: %0d cycles with in_ready outside fill, want 0", ir_bad);
    end
  endtask

  task automatic test_wrap();
    clear_obs();
    words.delete();
    for (int unsigned i = 0; i < 8; i++) words.push_back($urandom);
    xfer(15'h7FF0, 2, 0, 1);
    vectors++;
    if (tmo || act_q.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_count: writes %0d tmo %0d want 2", act_q.size(), tmo);
    end else begin
      vectors++;
      if (act_q[0].addr !== 15'h7FF0 || act_q[1].addr !== 15'h0000 ||
          act_q[1].data !== exp_data(1)) begin
        miscompares++;
        $display("FAIL wrap_addr: got %h,%h data1 %h want 7ff0,0000 / %h",
                 act_q[0].addr, act_q[1].addr, act_q[1].data, exp_data(1));
      end
      vectors++;
      if (en_cyc_q[1] - en_cyc_q[0] != 5) begin
        miscompares++;
        $display("FAIL wrap_rate: quadword spacing %0d want 5", en_cyc_q[1] - en_cyc_q[0]);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_obs();
    words.delete();
    xfer(15'h0040, 0, 0, 1);
    vectors++;
    if (tmo || act_q.size() != 0 || busy_cycles != 0) begin
      miscompares++;
      $display("FAIL zero_count: writes %0d busy_cycles %0d tmo %0d want 0/0/0",
               act_q.size(), busy_cycles, tmo);
    end
    vectors++;
    if (done_cyc != start_cyc + 1) begin
      miscompares++;
      $display("FAIL zero_done_timing: done@%0d want %0d", done_cyc, start_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w2[$];
    clear_obs();
    words.delete();
    for (int unsigned i = 0; i < 6; i++) words.push_back($urandom);
    xfer(15'h0300, 2, 0, 0);
    vectors++;
    if (tmo || act_q.size() != 1 || act_q[0].data !== exp_data(0)) begin
      miscompares++;
      $display("FAIL rstmid_first: writes %0d tmo %0d want 1 write before reset", act_q.size(), tmo);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.preload_LS_en, bus.busy, bus.done} !== 4'b0000 ||
        bus.preload_LS_addr !== 15'h0 || bus.preload_LS_data !== 128'h0) begin
      miscompares++;
      $display("FAIL rstmid_async: flags %b addr %h data %h want all 0",
               {bus.in_ready, bus.preload_LS_en, bus.busy, bus.done},
               bus.preload_LS_addr, bus.preload_LS_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    w2.delete();
    for (int unsigned i = 0; i < 4; i++) w2.push_back($urandom);
    words = w2;
    xfer(15'h0200, 1, 0, 1);
    vectors++;
    if (tmo || act_q.size() != 1 || act_q[0].addr !== 15'h0200 || act_q[0].data !== exp_data(0)) begin
      miscompares++;
      $display("FAIL rstmid_fresh: writes %0d tmo %0d data %h want 1 write of %h", act_q.size(),
               tmo, (act_q.size() > 0) ? act_q[0].data : 128'h0, exp_data(0));
    end
  endtask

  task automatic test_random();
    logic [14:0] a;
    int unsigned n;
    for (int unsigned t = 0; t < 6; t++) begin
      clear_obs();
      a = 15'($urandom);
      n = $urandom_range(1, 3);
      words.delete();
      for (int unsigned i = 0; i < 4 * n; i++) words.push_back($urandom);
      xfer(a, n, $urandom_range(0, 2), 1);
      vectors++;
      if (tmo || act_q.size() != n || en_long != 0 || ir_bad != 0) begin
        miscompares++;
        $display("FAIL rand%0d_shape: writes %0d want %0d tmo %0d en_long %0d ir_bad %0d",
                 t, act_q.size(), n, tmo, en_long, ir_bad);
      end else begin
        for (int unsigned i = 0; i < n; i++) begin
          vectors++;
          if (act_q[i].addr !== exp_addr(a, i) || act_q[i].data !== exp_data(i)) begin
            miscompares++;
            $display("FAIL rand%0d_write%0d: addr %h data %h want %h / %h", t, i,
                     act_q[i].addr, act_q[i].data, exp_addr(a, i), exp_data(i));
          end
        end
        vectors++;
        if (done_cyc != en_cyc_q[n-1] + 1) begin
          miscompares++;
          $display("FAIL rand%0d_done: done@%0d want %0d", t, done_cyc, en_cyc_q[n-1] + 1);
        end
      end
    end
  endtask

`ifdef LS_PRELOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] x;
    clear_obs();
    words = '{32'hFFFF0000, 32'h0000FFFF, 32'h12345678, 32'h12345678};
    x = 32'h0;
    foreach (words[i]) x = x ^ words[i];
    xfer(15'h0500, 1, 2, 1);
    vectors++;
    if (tmo || bus.checksum !== x || x !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL checksum: got %h want %h tmo %0d", bus.checksum, x, tmo);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.checksum !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL checksum_hold: got %h want ffffffff", bus.checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_qw();
    test_unaligned_gapped();
    test_wrap();
    test_zero_count();
    test_reset_mid();
    test_random();
`ifdef LS_PRELOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
